// File: rtl/instr_fetch_seq_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_seq_if
//   Bundles the handshake and bus signals of the instruction-fetch sequencer:
//   the execute-side redirect input, the instruction-memory request/response
//   bus, and the decode-side valid/ready output.
//
//   Signals:
//     redirect_valid / redirect_pc   branch/jump redirect from execute
//     imem_req / imem_addr           fetch request to instruction memory
//     imem_ack / imem_rdata          memory response for the current request
//     if_valid / if_pc / if_instr    {pc, instr} presented to decode
//     if_ready                       decode accepts the presented entry
//
//   Modports:
//     master  the fetch sequencer
//     slave   the surrounding system (execute, memory, decode)
// ---------------------------------------------------------------------------
interface instr_fetch_seq_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_pc, if_instr
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// instr_fetch_seq
//   Instruction-fetch sequencer. Owns the program counter, issues fetch
//   requests to instruction memory, collects returned words and presents
//   {pc, instr} pairs to decode over a valid/ready handshake. A redirect from
//   execute flushes buffered fetches and restarts fetching at the target.
//
//   Parameters:
//     RESET_PC   first fetch address after reset release
//     PC_STEP    byte increment between sequential fetches
//
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        instr_fetch_seq_if.master (redirect, imem bus, decode output)
//
//   Build option:
//     FETCH_SKID_EN  when defined, the output buffer is a 2-entry FIFO and
//                    imem_req depends only on registered occupancy. When
//                    undefined, a single output register is used and imem_req
//                    is combinationally enabled by a same-cycle decode pop.
// ---------------------------------------------------------------------------
module instr_fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_seq_if.master  bus
);

    localparam logic [31:0] STEP = PC_STEP;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DROP
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;       // next address to fetch into the buffer
    logic [31:0] addr_q;     // address on the bus; diverges from pc_q only in DROP
    logic [31:0] redirect_target;
    logic        buf_space;  // buffer can take an entry at the next edge
    logic        ack_take;   // current request completes this cycle
    logic        push;
    logic        pop;

    assign redirect_target = {bus.redirect_pc[31:2], 2'b00};
    assign bus.imem_addr   = addr_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        bus.imem_req = 1'b0;
        ack_take     = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        // DROP must keep the outstanding request alive until its ack.
        if (state_q == DROP) begin
            bus.imem_req = 1'b1;
        end else if (state_q == FETCH) begin
            bus.imem_req = buf_space;
        end
        ack_take = bus.imem_req && bus.imem_ack;
        // A word acked alongside a redirect belongs to the old path.
        push     = (state_q == FETCH) && ack_take && !bus.redirect_valid;
        pop      = bus.if_valid && bus.if_ready;
    end

    // -----------------------------------------------------------------------
    // Sequencer FSM and PC
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    if (bus.redirect_valid) begin
                        pc_q   <= redirect_target;
                        addr_q <= redirect_target;
                    end
                end
                FETCH: begin
                    if (bus.redirect_valid) begin
                        pc_q <= redirect_target;
                        if (bus.imem_req && !bus.imem_ack) begin
                            // Request in flight: hold its address until ack.
                            state_q <= DROP;
                        end else begin
                            addr_q <= redirect_target;
                        end
                    end else if (ack_take) begin
                        pc_q   <= pc_q + STEP;
                        addr_q <= pc_q + STEP;
                    end
                end
                DROP: begin
                    if (bus.redirect_valid) begin
                        pc_q <= redirect_target;
                    end
                    if (bus.imem_ack) begin
                        state_q <= FETCH;
                        addr_q  <= bus.redirect_valid ? redirect_target : pc_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output buffer
    // -----------------------------------------------------------------------
`ifdef FETCH_SKID_EN
    logic [1:0]  count_q;
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [31:0] pc_mem    [2];
    logic [31:0] instr_mem [2];

    // Registered occupancy only: no path from if_ready into imem_req.
    assign buf_space    = (count_q != 2'd2);
    assign bus.if_valid = (count_q != 2'd0);
    assign bus.if_pc    = pc_mem[rd_ptr_q];
    assign bus.if_instr = instr_mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            // NOTE: the two storage entries are reset because the head entry
            // drives if_pc/if_instr directly, and those must read 0 in reset.
            for (int i = 0; i < 2; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            // A coinciding pop has already been taken by decode; drop the rest.
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr_q]    <= pc_q;
                instr_mem[wr_ptr_q] <= bus.imem_rdata;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end
`else
    logic        valid_q;
    logic [31:0] pc_r;
    logic [31:0] instr_r;

    // Refill in the same cycle decode empties the register.
    assign buf_space    = !valid_q || bus.if_ready;
    assign bus.if_valid = valid_q;
    assign bus.if_pc    = pc_r;
    assign bus.if_instr = instr_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_r    <= '0;
            instr_r <= '0;
        end else if (bus.redirect_valid) begin
            valid_q <= 1'b0;
        end else if (push) begin
            valid_q <= 1'b1;
            pc_r    <= pc_q;
            instr_r <= bus.imem_rdata;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_seq
//   Directed self-checking bench for instr_fetch_seq. The memory model
//   returns addr ^ 32'h1357_9BDF; it acks combinationally in zero-wait mode
//   or under direct bench control otherwise. Inputs change and outputs are
//   sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch_seq;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic rst_n;
    logic zero_wait;
    logic manual_ack;
    int   n_checks;
    int   n_errors;

    instr_fetch_seq_if ifc ();

    instr_fetch_seq #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign ifc.imem_ack   = zero_wait ? ifc.imem_req : manual_ack;
    assign ifc.imem_rdata = ifc.imem_ack ? mem_word(ifc.imem_addr) : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks           = 0;
        n_errors           = 0;
        rst_n              = 1'b0;
        zero_wait          = 1'b1;
        manual_ack         = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = 32'h0;
        ifc.if_ready       = 1'b1;

        // ---- Reset state, then sequential zero-wait fetch ----
        step();
        step();
        check1 ("rst_req",    ifc.imem_req,  1'b0);
        check32("rst_addr",   ifc.imem_addr, RESET_PC);
        check1 ("rst_valid",  ifc.if_valid,  1'b0);
        check32("rst_pc",     ifc.if_pc,     32'h0);
        check32("rst_instr",  ifc.if_instr,  32'h0);
        rst_n = 1'b1;
        check1 ("idle_req",   ifc.imem_req,  1'b0);
        step();
        check1 ("seq_req0",   ifc.imem_req,  1'b1);
        check32("seq_addr0",  ifc.imem_addr, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check1 ("seq_valid", ifc.if_valid,  1'b1);
            check32("seq_pc",    ifc.if_pc,     32'(4 * (i - 1)));
            check32("seq_instr", ifc.if_instr,  mem_word(32'(4 * (i - 1))));
            check32("seq_addr",  ifc.imem_addr, 32'(4 * i));
        end

        // ---- Backpressure: if_ready low for 5 cycles after first instr ----
        rst_n        = 1'b0;
        ifc.if_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check1 ("bp_valid0", ifc.if_valid, 1'b1);
        check32("bp_pc0",    ifc.if_pc,    32'h0);
`ifdef FETCH_SKID_EN
        check1 ("bp_req0",   ifc.imem_req, 1'b1);
`else
        check1 ("bp_req0",   ifc.imem_req, 1'b0);
`endif
        for (int k = 0; k < 4; k++) begin
            step();
            check1 ("bp_hold_valid", ifc.if_valid, 1'b1);
            check32("bp_hold_pc",    ifc.if_pc,    32'h0);
            check32("bp_hold_instr", ifc.if_instr, mem_word(32'h0));
            check1 ("bp_hold_req",   ifc.imem_req, 1'b0);
`ifdef FETCH_SKID_EN
            check32("bp_hold_addr",  ifc.imem_addr, 32'h8);
`else
            check32("bp_hold_addr",  ifc.imem_addr, 32'h4);
`endif
        end
        ifc.if_ready = 1'b1;
        step();
        check1 ("bp_rel_valid1", ifc.if_valid, 1'b1);
        check32("bp_rel_pc1",    ifc.if_pc,    32'h4);
        check32("bp_rel_instr1", ifc.if_instr, mem_word(32'h4));
        step();
        check1 ("bp_rel_valid2", ifc.if_valid, 1'b1);
        check32("bp_rel_pc2",    ifc.if_pc,    32'h8);
        check32("bp_rel_instr2", ifc.if_instr, mem_word(32'h8));

        // ---- Redirect while the request for addr 8 is outstanding ----
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        check32("dr_addr8",     ifc.imem_addr, 32'h8);
        zero_wait = 1'b0;
        check1 ("dr_req8",      ifc.imem_req,  1'b1);
        step();
        check32("dr_addr8_hold", ifc.imem_addr, 32'h8);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h100;
        step();
        ifc.redirect_valid = 1'b0;
        check1 ("dr_drop_req",   ifc.imem_req,  1'b1);
        check32("dr_drop_addr",  ifc.imem_addr, 32'h8);
        check1 ("dr_drop_valid", ifc.if_valid,  1'b0);
        manual_ack = 1'b1;
        step();
        manual_ack = 1'b0;
        check32("dr_new_addr",   ifc.imem_addr, 32'h100);
        check1 ("dr_new_req",    ifc.imem_req,  1'b1);
        check1 ("dr_no_stale",   ifc.if_valid,  1'b0);
        zero_wait = 1'b1;
        step();
        check1 ("dr_tgt_valid",  ifc.if_valid,  1'b1);
        check32("dr_tgt_pc",     ifc.if_pc,     32'h100);
        check32("dr_tgt_instr",  ifc.if_instr,  mem_word(32'h100));
        check32("dr_tgt_addr",   ifc.imem_addr, 32'h104);

        // ---- Redirect to 0x203 in the same cycle as an ack ----
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h203;
        check1 ("ra_ack_now",    ifc.imem_ack,  1'b1);
        step();
        ifc.redirect_valid = 1'b0;
        check1 ("ra_flush",      ifc.if_valid,  1'b0);
        check32("ra_addr",       ifc.imem_addr, 32'h200);
        step();
        check1 ("ra_valid",      ifc.if_valid,  1'b1);
        check32("ra_pc",         ifc.if_pc,     32'h200);
        check32("ra_instr",      ifc.if_instr,  mem_word(32'h200));

        // ---- Flush with if_ready low, then PC wrap ----
        ifc.if_ready       = 1'b0;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'hFFFF_FFFC;
        step();
        ifc.redirect_valid = 1'b0;
        ifc.if_ready       = 1'b1;
        check1 ("wr_flush",      ifc.if_valid,  1'b0);
        check32("wr_addr",       ifc.imem_addr, 32'hFFFF_FFFC);
        step();
        check32("wr_pc_top",     ifc.if_pc,     32'hFFFF_FFFC);
        check32("wr_instr_top",  ifc.if_instr,  mem_word(32'hFFFF_FFFC));
        check32("wr_addr_zero",  ifc.imem_addr, 32'h0);
        step();
        check1 ("wr_valid0",     ifc.if_valid,  1'b1);
        check32("wr_pc_zero",    ifc.if_pc,     32'h0);
        check32("wr_instr_zero", ifc.if_instr,  mem_word(32'h0));

        // ---- Asynchronous reset mid-request with a late ack ----
        zero_wait  = 1'b0;
        manual_ack = 1'b0;
        check1 ("ar_pending",    ifc.imem_req,  1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check1 ("ar_req",        ifc.imem_req,  1'b0);
        check32("ar_addr",       ifc.imem_addr, RESET_PC);
        check1 ("ar_valid",      ifc.if_valid,  1'b0);
        check32("ar_pc",         ifc.if_pc,     32'h0);
        check32("ar_instr",      ifc.if_instr,  32'h0);
        step();
        manual_ack = 1'b1;
        step();
        manual_ack = 1'b0;
        check1 ("ar_late_valid", ifc.if_valid,  1'b0);
        check32("ar_late_addr",  ifc.imem_addr, RESET_PC);
        rst_n = 1'b1;
        check1 ("ar_idle_req",   ifc.imem_req,  1'b0);
        step();
        check1 ("ar_fetch_req",  ifc.imem_req,  1'b1);
        check32("ar_fetch_addr", ifc.imem_addr, RESET_PC);
        check1 ("ar_no_ghost",   ifc.if_valid,  1'b0);
        zero_wait = 1'b1;
        step();
        check1 ("ar_valid0",     ifc.if_valid,  1'b1);
        check32("ar_pc0",        ifc.if_pc,     RESET_PC);
        check32("ar_instr0",     ifc.if_instr,  mem_word(RESET_PC));
        step();
        check32("ar_pc1",        ifc.if_pc,     RESET_PC + 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
